fpu_tagged_issue: RTL and testbench

- Multi-outstanding front end for the FPU datapath. Replaces the single-op en/ready stall scheme.
- Accepts ops from the CPU over a valid/ready handshake and allocates an in-order slot per op.
- Issues each op with a tag to a variable-latency core, which may complete ops out of order.
- Returns results strictly in issue order. Supports pipeline flush.

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/fpu_tagged_issue_if.sv | 46 ++++
 rtl/fpu_rob.sv | 67 ++++++
 rtl/fpu_tagged_issue.sv | 104 ++++++++++
 tb/tb_fpu_tagged_issue.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - FPU op encoding, datapath widths and reorder-slot type
package fpu_pkg;

    localparam int FPU_DW   = 32;
    localparam int FPU_CTLW = 5;

    typedef enum logic [FPU_CTLW-1:0] {
        fadd    = 5'd0,
        fsub    = 5'd1,
        fmul    = 5'd2,
        finv    = 5'd3,
        fdiv    = 5'd4,
        fhalf   = 5'd5,
        ftoi    = 5'd6,
        itof    = 5'd7,
        floor   = 5'd8,
        feq     = 5'd9,
        fle     = 5'd10,
        fabs    = 5'd11,
        fneg    = 5'd12,
        fless   = 5'd13,
        fmin    = 5'd14,
        fmax    = 5'd15,
        fiszero = 5'd16,
        fispos  = 5'd17,
        fisneg  = 5'd18,
        sqrt    = 5'd19,
        fsqr    = 5'd20
    } fpu_op_e;

    typedef struct packed {
        logic                valid;
        logic                done;
        logic [FPU_CTLW-1:0] ctl;
        logic [FPU_DW-1:0]   y;
    } fpu_slot_t;

endpackage

// File: rtl/fpu_tagged_issue_if.sv
// rtl/fpu_tagged_issue_if.sv - request, core issue/completion, result and control signals
interface fpu_tagged_issue_if #(
    parameter int DEPTH = 8,
    parameter int DW    = 32,
    parameter int CTLW  = 5
);
    localparam int TAGW = $clog2(DEPTH) + 1;
    localparam int OCCW = $clog2(DEPTH) + 1;

    logic            req_valid;
    logic            req_ready;
    logic [CTLW-1:0] req_ctl;
    logic [DW-1:0]   req_x1;
    logic [DW-1:0]   req_x2;
    logic            core_valid;
    logic            core_ready;
    logic [CTLW-1:0] core_ctl;
    logic [DW-1:0]   core_x1;
    logic [DW-1:0]   core_x2;
    logic [TAGW-1:0] core_tag;
    logic            core_done;
    logic [TAGW-1:0] core_rtag;
    logic [DW-1:0]   core_y;
    logic            res_valid;
    logic            res_ready;
    logic [CTLW-1:0] res_ctl;
    logic [DW-1:0]   res_y;
    logic            flush;
    logic [OCCW-1:0] occupancy;
    logic            err_tag;

    modport slave (
        input  req_valid, req_ctl, req_x1, req_x2, core_ready,
               core_done, core_rtag, core_y, res_ready, flush,
        output req_ready, core_valid, core_ctl, core_x1, core_x2, core_tag,
               res_valid, res_ctl, res_y, occupancy, err_tag
    );

    modport master (
        output req_valid, req_ctl, req_x1, req_x2, core_ready,
               core_done, core_rtag, core_y, res_ready, flush,
        input  req_ready, core_valid, core_ctl, core_x1, core_x2, core_tag,
               res_valid, res_ctl, res_y, occupancy, err_tag
    );

endinterface

// File: rtl/fpu_rob.sv
// rtl/fpu_rob.sv - in-order slot ring: allocate at tail, complete by index, retire at head
module fpu_rob
    import fpu_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int IW    = $clog2(DEPTH),
    localparam int OCCW  = IW + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush_i,
    input  logic                alloc_i,
    input  logic [FPU_CTLW-1:0] alloc_ctl_i,
    output logic [IW-1:0]       tail_o,
    input  logic                cpl_valid_i,
    input  logic [IW-1:0]       cpl_idx_i,
    input  logic [FPU_DW-1:0]   cpl_y_i,
    output logic                cpl_bad_o,
    input  logic                retire_i,
    output fpu_slot_t           head_o,
    output logic [OCCW-1:0]     occupancy_o,
    output logic                full_o
);

    fpu_slot_t       slots_q [DEPTH];
    logic [IW-1:0]   head_q;
    logic [IW-1:0]   tail_q;
    logic [OCCW-1:0] occ_q;

    assign head_o      = slots_q[head_q];
    assign tail_o      = tail_q;
    assign occupancy_o = occ_q;
    assign full_o      = (occ_q == OCCW'(DEPTH));
    // A completion is only legal for a live slot that has not yet produced its result.
    assign cpl_bad_o   = !slots_q[cpl_idx_i].valid || slots_q[cpl_idx_i].done;

    always_ff @(posedge clk) begin
        if (!rstn || flush_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            if (cpl_valid_i && !cpl_bad_o) begin
                slots_q[cpl_idx_i].done <= 1'b1;
                slots_q[cpl_idx_i].y    <= cpl_y_i;
            end
            if (retire_i) begin
                slots_q[head_q].valid <= 1'b0;
                slots_q[head_q].done  <= 1'b0;
                head_q                <= head_q + IW'(1);
            end
            if (alloc_i) begin
                slots_q[tail_q] <= '{valid: 1'b1, done: 1'b0, ctl: alloc_ctl_i, y: '0};
                tail_q          <= tail_q + IW'(1);
            end
            case ({alloc_i, retire_i})
                2'b10:   occ_q <= occ_q + OCCW'(1);
                2'b01:   occ_q <= occ_q - OCCW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/fpu_tagged_issue.sv
// rtl/fpu_tagged_issue.sv - tagged multi-outstanding FPU front end with in-order retire and flush
module fpu_tagged_issue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = FPU_DW,
    parameter int CTLW  = FPU_CTLW,
    parameter int TAGW  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    fpu_tagged_issue_if.slave  bus
);

    localparam int IW = TAGW - 1;

    logic            core_valid_q, core_valid_d;
    logic [CTLW-1:0] core_ctl_q;
    logic [DW-1:0]   core_x1_q;
    logic [DW-1:0]   core_x2_q;
    logic [TAGW-1:0] core_tag_q;
    logic            epoch_q;
    logic            err_tag_q;

    logic            full;
    logic            accept;
    logic            cpl_valid;
    logic            cpl_bad;
    logic            retire;
    logic [IW-1:0]   tail;
    fpu_slot_t       head;

    assign bus.req_ready = rstn && !bus.flush && !full && !(core_valid_q && !bus.core_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    // Results from an earlier epoch belong to flushed ops and are dropped without complaint.
    assign cpl_valid     = bus.core_done && !bus.flush && (bus.core_rtag[TAGW-1] == epoch_q);
    assign bus.res_valid = head.valid && head.done;
    assign retire        = bus.res_valid && bus.res_ready && !bus.flush;

    assign bus.res_ctl    = head.ctl;
    assign bus.res_y      = head.y;
    assign bus.core_valid = core_valid_q;
    assign bus.core_ctl   = core_ctl_q;
    assign bus.core_x1    = core_x1_q;
    assign bus.core_x2    = core_x2_q;
    assign bus.core_tag   = core_tag_q;
    assign bus.err_tag    = err_tag_q;

    fpu_rob #(.DEPTH(DEPTH)) u_rob (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (bus.flush),
        .alloc_i     (accept),
        .alloc_ctl_i (bus.req_ctl),
        .tail_o      (tail),
        .cpl_valid_i (cpl_valid),
        .cpl_idx_i   (bus.core_rtag[IW-1:0]),
        .cpl_y_i     (bus.core_y),
        .cpl_bad_o   (cpl_bad),
        .retire_i    (retire),
        .head_o      (head),
        .occupancy_o (bus.occupancy),
        .full_o      (full)
    );

    always_comb begin
        core_valid_d = core_valid_q;
        if (accept) begin
            core_valid_d = 1'b1;
        end else if (bus.core_ready) begin
            core_valid_d = 1'b0;
        end
        if (bus.flush) begin
            core_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            core_valid_q <= 1'b0;
            core_ctl_q   <= '0;
            core_x1_q    <= '0;
            core_x2_q    <= '0;
            core_tag_q   <= '0;
            epoch_q      <= 1'b0;
            err_tag_q    <= 1'b0;
        end else begin
            core_valid_q <= core_valid_d;
            if (bus.flush) begin
                epoch_q <= ~epoch_q;
            end
            if (accept) begin
                core_ctl_q <= bus.req_ctl;
                core_x1_q  <= bus.req_x1;
                core_x2_q  <= bus.req_x2;
                core_tag_q <= {epoch_q, tail};
            end
            if (cpl_valid && cpl_bad) begin
                err_tag_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_tagged_issue.sv
// tb/tb_fpu_tagged_issue.sv - randomized and directed bench with an in-order queue reference model
module tb_fpu_tagged_issue;
    import fpu_pkg::*;

    localparam int DEPTH = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fpu_tagged_issue_if #(.DEPTH(DEPTH), .DW(FPU_DW), .CTLW(FPU_CTLW)) bus ();

    fpu_tagged_issue #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [4:0]  ctl;
        int          slot;
        bit          done;
        logic [31:0] y;
    } rob_ent_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] y;
        int          cnt;
    } core_ent_t;

    rob_ent_t    rob_q[$];
    core_ent_t   pool_q[$];
    int          lat_q[$];
    logic [31:0] yov_q[$];

    int          m_tail = 0;
    bit          m_epoch = 0, m_err = 0, m_iv = 0, m_last_acc = 0;
    logic [4:0]  m_ictl = '0;
    logic [31:0] m_ix1 = '0, m_ix2 = '0;
    logic [3:0]  m_itag = '0;

    bit          d_req_valid = 0, d_core_ready = 1, d_res_ready = 1, d_flush = 0;
    logic [4:0]  d_ctl = '0;
    logic [31:0] d_x1 = '0, d_x2 = '0;
    bit          inj_valid = 0;
    logic [3:0]  inj_tag = '0;
    int          lat_max = 4;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] core_fn(input logic [4:0] ctl, input logic [31:0] x1,
                                            input logic [31:0] x2);
        return (x1 ^ {x2[15:0], x2[31:16]}) + {27'd0, ctl};
    endfunction

    task automatic step();
        int          elig[$];
        int          pick;
        bit          exp_rr, exp_rv, dn, found;
        logic [3:0]  rt;
        logic [31:0] ry;
        core_ent_t   ce;
        @(negedge clk);
        pick = -1;
        dn   = 0;
        rt   = '0;
        ry   = '0;
        foreach (pool_q[i]) if (pool_q[i].cnt <= 1) elig.push_back(i);
        if (inj_valid) begin
            dn = 1;
            rt = inj_tag;
            ry = 32'hDEAD_BEEF;
        end else if (rstn && !d_flush && elig.size() > 0) begin
            pick = elig[$urandom_range(elig.size() - 1)];
            dn   = 1;
            rt   = pool_q[pick].tag;
            ry   = pool_q[pick].y;
        end
        bus.req_valid  = d_req_valid;
        bus.req_ctl    = d_ctl;
        bus.req_x1     = d_x1;
        bus.req_x2     = d_x2;
        bus.core_ready = d_core_ready;
        bus.res_ready  = d_res_ready;
        bus.flush      = d_flush;
        bus.core_done  = dn;
        bus.core_rtag  = rt;
        bus.core_y     = ry;
        #1;
        exp_rr = rstn && !d_flush && rob_q.size() < DEPTH && !(m_iv && !d_core_ready);
        exp_rv = rob_q.size() > 0 && rob_q[0].done;
        check_val("req_ready", bus.req_ready, exp_rr);
        check_val("occupancy", bus.occupancy, rob_q.size());
        check_val("err_tag", bus.err_tag, m_err);
        check_val("core_valid", bus.core_valid, m_iv);
        if (m_iv) begin
            check_val("core_tag", bus.core_tag, m_itag);
            check_val("core_ctl", bus.core_ctl, m_ictl);
            check_val("core_x1", bus.core_x1, m_ix1);
            check_val("core_x2", bus.core_x2, m_ix2);
        end
        check_val("res_valid", bus.res_valid, exp_rv);
        if (exp_rv) begin
            check_val("res_ctl", bus.res_ctl, rob_q[0].ctl);
            check_val("res_y", bus.res_y, rob_q[0].y);
        end
        @(posedge clk);
        m_last_acc = 0;
        if (!rstn) begin
            rob_q.delete();
            pool_q.delete();
            m_tail  = 0;
            m_epoch = 0;
            m_err   = 0;
            m_iv    = 0;
        end else if (d_flush) begin
            rob_q.delete();
            m_tail  = 0;
            m_iv    = 0;
            m_epoch = !m_epoch;
            // outstanding tags from two epochs back would alias the new epoch
            for (int i = pool_q.size() - 1; i >= 0; i--)
                if (pool_q[i].tag[3] == m_epoch) pool_q.delete(i);
        end else begin
            foreach (pool_q[i]) pool_q[i].cnt--;
            if (pick >= 0) pool_q.delete(pick);
            if (dn && rt[3] == m_epoch) begin
                found = 0;
                foreach (rob_q[i]) begin
                    if (!found && rob_q[i].slot == int'(rt[2:0]) && !rob_q[i].done) begin
                        rob_q[i].done = 1;
                        rob_q[i].y    = ry;
                        found         = 1;
                    end
                end
                if (!found) m_err = 1;
            end
            if (exp_rv && d_res_ready) void'(rob_q.pop_front());
            if (m_iv && d_core_ready) begin
                ce.tag = m_itag;
                ce.y   = (yov_q.size() > 0) ? yov_q.pop_front() : core_fn(m_ictl, m_ix1, m_ix2);
                ce.cnt = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(lat_max, 1));
                pool_q.push_back(ce);
                m_iv = 0;
            end
            if (d_req_valid && exp_rr) begin
                rob_q.push_back('{ctl: d_ctl, slot: m_tail, done: 0, y: '0});
                m_iv       = 1;
                m_ictl     = d_ctl;
                m_ix1      = d_x1;
                m_ix2      = d_x2;
                m_itag     = {m_epoch, 3'(m_tail)};
                m_tail     = (m_tail + 1) % DEPTH;
                m_last_acc = 1;
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        d_req_valid = 0;
        d_flush     = 0;
        steps(2);
        rstn = 1'b1;
    endtask

    task automatic req(input logic [4:0] ctl, input logic [31:0] x1, input logic [31:0] x2);
        d_req_valid = 1;
        d_ctl       = ctl;
        d_x1        = x1;
        d_x2        = x2;
    endtask

    initial begin
        int       max_occ;
        bit       saw_res;
        logic [3:0] held_tag;

        // Test 1: reset
        do_reset();
        step();
        #1;
        check_val("t1_req_ready", bus.req_ready, 1);
        check_val("t1_occupancy", bus.occupancy, 0);

        // Test 2: single fadd, L=3, result visible in cycle 5
        d_res_ready = 0;
        lat_q.push_back(3);
        yov_q.push_back(32'h4040_0000);
        req(5'(fadd), 32'h3F80_0000, 32'h4000_0000);
        step();
        d_req_valid = 0;
        steps(3);
        #1;
        check_val("t2_res_valid_early", bus.res_valid, 0);
        step();
        #1;
        check_val("t2_res_valid", bus.res_valid, 1);
        check_val("t2_res_y", bus.res_y, 32'h4040_0000);
        check_val("t2_res_ctl", bus.res_ctl, 0);
        d_res_ready = 1;
        steps(2);

        // Test 3: out-of-order completion C, A, B retires as A, B, C
        lat_q.push_back(5);
        lat_q.push_back(6);
        lat_q.push_back(2);
        max_occ = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 3) req(5'(fmul + i), $urandom, $urandom);
            else d_req_valid = 0;
            step();
            #1;
            if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
        end
        check_val("t3_max_occ", max_occ, 3);
        check_val("t3_final_occ", bus.occupancy, 0);

        // Test 4: fill to DEPTH, one retire reopens, slot 0 reused
        do_reset();
        lat_max     = 2;
        d_res_ready = 0;
        for (int i = 0; i < 12; i++) begin
            req(5'($urandom_range(20)), $urandom, $urandom);
            step();
        end
        #1;
        check_val("t4_occ_full", bus.occupancy, DEPTH);
        check_val("t4_ready_full", bus.req_ready, 0);
        d_res_ready = 1;
        step();
        d_res_ready = 0;
        #1;
        check_val("t4_ready_after_retire", bus.req_ready, 1);
        step();
        #1;
        check_val("t4_reuse_valid", bus.core_valid, 1);
        check_val("t4_reuse_tag", bus.core_tag, 4'b0000);
        d_req_valid = 0;
        d_res_ready = 1;
        steps(20);

        // Test 5: flush discards in-flight ops; stale results are dropped silently
        for (int i = 0; i < 3; i++) lat_q.push_back(8);
        d_res_ready = 1;
        for (int i = 0; i < 3; i++) begin
            req(5'(fsub), $urandom, $urandom);
            step();
        end
        d_req_valid = 0;
        step();
        d_flush = 1;
        step();
        d_flush = 0;
        saw_res = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            #1;
            if (bus.res_valid === 1'b1) saw_res = 1;
        end
        check_val("t5_no_res", saw_res, 0);
        check_val("t5_err_tag", bus.err_tag, 0);
        req(5'(fdiv), $urandom, $urandom);
        step();
        d_req_valid = 0;
        #1;
        check_val("t5_new_tag", bus.core_tag, 4'b1000);
        steps(12);
        #1;
        check_val("t5_drained", bus.occupancy, 0);

        // Random phase
        lat_max = 8;
        for (int c = 0; c < 3000; c++) begin
            if (!d_req_valid || m_last_acc) begin
                d_req_valid = ($urandom_range(9) < 6);
                d_ctl       = 5'($urandom_range(20));
                d_x1        = $urandom;
                d_x2        = $urandom;
            end
            d_core_ready = ($urandom_range(9) < 7);
            d_res_ready  = ($urandom_range(9) < 7);
            d_flush      = ($urandom_range(127) == 0);
            step();
        end
        d_req_valid  = 0;
        d_flush      = 0;
        d_core_ready = 1;
        d_res_ready  = 1;
        steps(40);

        // Test 6: bad tag sets sticky err_tag; issue stage holds under backpressure
        inj_tag   = {m_epoch, 3'd5};
        inj_valid = 1;
        step();
        inj_valid = 0;
        #1;
        check_val("t6_err_set", bus.err_tag, 1);
        steps(3);
        #1;
        check_val("t6_err_sticky", bus.err_tag, 1);
        d_core_ready = 0;
        req(5'(sqrt), $urandom, $urandom);
        step();
        held_tag = m_itag;
        req(5'(fabs), $urandom, $urandom);
        steps(4);
        #1;
        check_val("t6_core_valid_held", bus.core_valid, 1);
        check_val("t6_core_tag_held", bus.core_tag, held_tag);
        check_val("t6_req_ready_stall", bus.req_ready, 0);
        d_core_ready = 1;
        step();
        d_req_valid = 0;
        steps(20);
        #1;
        check_val("t6_final_occ", bus.occupancy, 0);
        check_val("t6_err_final", bus.err_tag, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
